// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Brief    : Instruction fetch stage. Owns the architectural PC, drives the
//            instruction-memory request, captures returned words into the
//            IF/ID register and halts on an HLT fetch until flushed or reset.
//            Optional macro FETCH_PERF_CNT_EN adds saturating fetch, bubble
//            and flush event counters.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [3:0]  HALT_OPCODE = 4'hF,
    parameter logic [15:0] NOP_INSTR   = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] Next_pc,
    input  logic        Flush,
    input  logic        Stall,
    input  logic        Imem_rdy,
    input  logic [15:0] Imem_data,
    output logic        Imem_req,
    output logic [15:0] Imem_addr,
    output logic [15:0] Pc,
    output logic [15:0] If_instr,
    output logic [15:0] If_pc,
    output logic        If_valid,
    output logic        Halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0] Fetch_cnt,
    output logic [15:0] Bubble_cnt,
    output logic [15:0] Flush_cnt
`endif
);

    typedef enum logic [0:0] {
        S_RUN    = 1'b0,
        S_HALTED = 1'b1
    } state_t;

    localparam logic [15:0] c_cnt_max = 16'hFFFF;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_pc;
    logic [15:0] w_pc_nxt;
    logic [15:0] r_if_instr;
    logic [15:0] w_if_instr_nxt;
    logic [15:0] r_if_pc;
    logic [15:0] w_if_pc_nxt;
    logic        r_if_valid;
    logic        w_if_valid_nxt;

    logic        w_run;
    logic        w_accept;
    logic        w_bubble;
    logic        w_is_hlt;

    assign w_run     = (r_state == S_RUN);
    assign w_accept  = w_run && !Stall && !Flush && Imem_rdy;
    assign w_bubble  = w_run && !Stall && !Flush && !Imem_rdy;
    assign w_is_hlt  = (Imem_data[15:12] == HALT_OPCODE);

    assign Imem_req  = w_run && !Stall && !Flush;
    assign Imem_addr = r_pc;
    assign Pc        = r_pc;
    assign If_instr  = r_if_instr;
    assign If_pc     = r_if_pc;
    assign If_valid  = r_if_valid;
    assign Halted    = (r_state == S_HALTED);

    // Next-state and IF/ID update: Flush beats Stall beats accept beats wait
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_if_instr_nxt = r_if_instr;
        w_if_pc_nxt    = r_if_pc;
        w_if_valid_nxt = r_if_valid;
        case (r_state)
            S_RUN: begin
                if (Flush) begin
                    w_pc_nxt       = Next_pc;
                    w_if_valid_nxt = 1'b0;
                    w_if_instr_nxt = NOP_INSTR;
                end else if (Stall) begin
                    w_pc_nxt       = r_pc;
                end else if (Imem_rdy) begin
                    w_if_instr_nxt = Imem_data;
                    w_if_pc_nxt    = r_pc;
                    w_if_valid_nxt = 1'b1;
                    if (w_is_hlt) begin
                        w_state_nxt = S_HALTED;
                    end else begin
                        w_pc_nxt    = Next_pc;
                    end
                end else begin
                    w_if_valid_nxt = 1'b0;
                end
            end
            S_HALTED: begin
                if (Flush) begin
                    // An older branch squashed the speculatively fetched HLT
                    w_pc_nxt       = Next_pc;
                    w_if_valid_nxt = 1'b0;
                    w_if_instr_nxt = NOP_INSTR;
                    w_state_nxt    = S_RUN;
                end else if (!Stall) begin
                    w_if_valid_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = S_RUN;
            end
        endcase
    end

    // State, PC and IF/ID registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_RUN;
            r_pc       <= RESET_PC;
            r_if_instr <= NOP_INSTR;
            r_if_pc    <= 16'h0000;
            r_if_valid <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_if_instr <= w_if_instr_nxt;
            r_if_pc    <= w_if_pc_nxt;
            r_if_valid <= w_if_valid_nxt;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] r_fetch_cnt;
    logic [15:0] r_bubble_cnt;
    logic [15:0] r_flush_cnt;

    assign Fetch_cnt  = r_fetch_cnt;
    assign Bubble_cnt = r_bubble_cnt;
    assign Flush_cnt  = r_flush_cnt;

    // Saturating event counters; only flushes are counted while halted
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fetch_cnt  <= 16'h0000;
            r_bubble_cnt <= 16'h0000;
            r_flush_cnt  <= 16'h0000;
        end else begin
            if (w_accept && (r_fetch_cnt != c_cnt_max)) begin
                r_fetch_cnt <= r_fetch_cnt + 16'd1;
            end
            if (w_bubble && (r_bubble_cnt != c_cnt_max)) begin
                r_bubble_cnt <= r_bubble_cnt + 16'd1;
            end
            if (Flush && (r_flush_cnt != c_cnt_max)) begin
                r_flush_cnt <= r_flush_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire
